// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-file slave: FSM states and bus bit meanings.
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDR       = 4'd1,
    ADDR_ACK   = 4'd2,
    OFFSET     = 4'd3,
    OFFSET_ACK = 4'd4,
    WDATA      = 4'd5,
    WDATA_ACK  = 4'd6,
    RDATA      = 4'd7,
    RDATA_ACK  = 4'd8,
    IGNORE     = 4'd9
  } i2cState_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Register-file event and status bundle produced by the I2C slave.
interface i2c_slave_regfile_if;
  logic       oWriteEn;
  logic [7:0] ovWrOffset;
  logic [7:0] ovWrData;
  logic       oReadEn;
  logic       oBusy;
  logic [3:0] ovState;

  modport slave  (output oWriteEn, ovWrOffset, ovWrData, oReadEn, oBusy, ovState);
  modport master (input  oWriteEn, ovWrOffset, ovWrData, oReadEn, oBusy, ovState);
endinterface

// File: rtl/i2c_bus_sync.sv
// Pin synchronisers for SCL/SDA plus SCL edge and START/STOP detection.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iClk,
  input  logic iRstn,
  input  logic scl,
  input  logic sda,
  output logic sdaLvl,
  output logic sclRise,
  output logic sclFall,
  output logic startDet,
  output logic stopDet
);
  logic [SYNC_STAGES-1:0] sclSync, sdaSync;
  logic sclPrev, sdaPrev, sclLvl;

  // Idle bus is high, so reset to 1 keeps reset release from looking like an edge.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      sclSync <= '1;
      sdaSync <= '1;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], scl};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], sda};
      sclPrev <= sclLvl;
      sdaPrev <= sdaLvl;
    end
  end

  assign sclLvl   = sclSync[SYNC_STAGES-1];
  assign sdaLvl   = sdaSync[SYNC_STAGES-1];
  assign sclRise  =  sclLvl & ~sclPrev;
  assign sclFall  = ~sclLvl &  sclPrev;
  assign startDet =  sclLvl &  sclPrev &  sdaPrev & ~sdaLvl;
  assign stopDet  =  sclLvl &  sclPrev & ~sdaPrev &  sdaLvl;
endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing DEPTH byte registers behind an auto-incrementing pointer.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h08,
  parameter int         DEPTH       = 16,
  parameter logic [7:0] INIT_VALUE  = 8'h23,
  parameter int         SYNC_STAGES = 2
) (
  input  logic iClk,
  input  logic iRstn,
  input  logic SCL,
  inout  wire  SDA,
  i2c_slave_regfile_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  i2cState_e  state;
  logic [2:0] bitCnt;
  logic [6:0] shiftReg, txReg;
  logic [7:0] pointer, ptrNext, wrOffset, wrData, rxByte, offsetMod;
  logic [7:0] regs [DEPTH];
  logic       sdaDrive, rwFlag, writeEn, readEn, busy, lastBit;
  logic       sdaLvl, sclRise, sclFall, startDet, stopDet;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
    .iClk(iClk), .iRstn(iRstn), .scl(SCL), .sda(SDA),
    .sdaLvl(sdaLvl), .sclRise(sclRise), .sclFall(sclFall),
    .startDet(startDet), .stopDet(stopDet)
  );

  assign SDA       = sdaDrive ? 1'b0 : 1'bz;
  assign rxByte    = {shiftReg, sdaLvl};
  assign lastBit   = sclRise && (bitCnt == 3'd7);
  assign ptrNext   = (pointer == 8'(DEPTH-1)) ? 8'd0 : pointer + 8'd1;
  assign offsetMod = 8'({1'b0, rxByte} % 9'(DEPTH));

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state    <= IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      txReg    <= '0;
      pointer  <= '0;
      sdaDrive <= 1'b0;
      rwFlag   <= 1'b0;
      writeEn  <= 1'b0;
      readEn   <= 1'b0;
      busy     <= 1'b0;
      wrOffset <= '0;
      wrData   <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= INIT_VALUE;
    end else begin
      writeEn <= 1'b0;
      readEn  <= 1'b0;
      if (sclRise) shiftReg <= rxByte[6:0];
      if (sclRise && (state inside {ADDR, OFFSET, WDATA, RDATA})) bitCnt <= bitCnt + 3'd1;

      if (startDet) begin
        state    <= ADDR;
        bitCnt   <= '0;
        sdaDrive <= 1'b0;
        busy     <= 1'b1;
      end else if (stopDet) begin
        state    <= IDLE;
        sdaDrive <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ADDR: if (lastBit) begin
            if (rxByte[7:1] == SLAVE_ADDR) begin
              rwFlag <= rxByte[0];
              state  <= ADDR_ACK;
            end else begin
              state  <= IGNORE;
            end
          end
          // Drive on the fall that ends bit 8; release/exit on the fall that ends the slot.
          ADDR_ACK, OFFSET_ACK, WDATA_ACK: if (sclFall) begin
            if (!sdaDrive) begin
              sdaDrive <= 1'b1;
            end else if (state == ADDR_ACK && rwFlag == RW_READ) begin
              txReg    <= regs[pointer[AW-1:0]][6:0];
              sdaDrive <= ~regs[pointer[AW-1:0]][7];
              readEn   <= 1'b1;
              state    <= RDATA;
            end else begin
              sdaDrive <= 1'b0;
              state    <= (state == ADDR_ACK) ? OFFSET : WDATA;
            end
          end
          OFFSET: if (lastBit) begin
            pointer <= offsetMod;
            state   <= OFFSET_ACK;
          end
          WDATA: if (lastBit) begin
            regs[pointer[AW-1:0]] <= rxByte;
            writeEn  <= 1'b1;
            wrOffset <= pointer;
            wrData   <= rxByte;
            pointer  <= ptrNext;
            state    <= WDATA_ACK;
          end
          // bitCnt wraps to 0 after the eighth rise, so a fall seen at 0 ends the byte.
          RDATA: if (sclFall) begin
            if (bitCnt == 3'd0) begin
              sdaDrive <= 1'b0;
              state    <= RDATA_ACK;
            end else begin
              sdaDrive <= ~txReg[6];
              txReg    <= {txReg[5:0], 1'b0};
            end
          end
          RDATA_ACK: if (sclFall) begin
            if (shiftReg[0] == ACK) begin
              pointer  <= ptrNext;
              txReg    <= regs[ptrNext[AW-1:0]][6:0];
              sdaDrive <= ~regs[ptrNext[AW-1:0]][7];
              readEn   <= 1'b1;
              state    <= RDATA;
            end else begin
              state    <= IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.oWriteEn   = writeEn;
  assign bus.ovWrOffset = wrOffset;
  assign bus.ovWrData   = wrData;
  assign bus.oReadEn    = readEn;
  assign bus.oBusy      = busy;
  assign bus.ovState    = state;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench: bit-banged I2C master, array/pointer reference model, write scoreboard monitor.
module tb_i2c_slave_regfile;
  import i2c_pkg::*;

  localparam int         DEPTH = 16;
  localparam logic [6:0] SADDR = 7'h08;
  localparam int         Q     = 5;

  typedef logic [7:0] byteQ_t [$];

  logic iClk = 1'b0, iRstn = 1'b0, scl = 1'b1, mDrive = 1'b0;
  wire  sda;
  pullup (sda);
  assign sda = mDrive ? 1'b0 : 1'bz;

  i2c_slave_regfile_if busIf();

  i2c_slave_regfile #(.SLAVE_ADDR(SADDR), .DEPTH(DEPTH), .INIT_VALUE(8'h23), .SYNC_STAGES(2)) dut (
    .iClk(iClk), .iRstn(iRstn), .SCL(scl), .SDA(sda), .bus(busIf)
  );

  always #5 iClk = ~iClk;

  logic [7:0]  mem [DEPTH];
  int          ptr, expRdEn, rdEnCnt, quietHits, nChecks, nFails;
  bit          quiet;
  logic [15:0] wrQ [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h23;
    ptr = 0;
  endfunction

  // Monitor: pops the expected write whenever the DUT reports one.
  always @(negedge iClk) begin
    if (busIf.oReadEn) rdEnCnt++;
    if (quiet && !mDrive && sda === 1'b0) quietHits++;
    if (busIf.oWriteEn) begin
      if (wrQ.size() == 0) begin
        nChecks++; nFails++;
        $display("FAIL unexpected write: got off %0h data %0h, expected none", busIf.ovWrOffset, busIf.ovWrData);
      end else begin
        check("write event", {16'h0, busIf.ovWrOffset, busIf.ovWrData}, {16'h0, wrQ.pop_front()});
      end
    end
  end

  initial begin
    repeat (90000) @(posedge iClk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  task automatic waitQ();
    repeat (Q) @(negedge iClk);
  endtask

  task automatic busStart();
    mDrive = 1'b0; waitQ(); scl = 1'b1; waitQ(); mDrive = 1'b1; waitQ(); scl = 1'b0; waitQ();
  endtask

  task automatic busStop();
    mDrive = 1'b1; waitQ(); scl = 1'b1; waitQ(); mDrive = 1'b0; waitQ(); waitQ();
  endtask

  task automatic sendBit(bit b);
    mDrive = !b; waitQ(); scl = 1'b1; waitQ(); waitQ(); scl = 1'b0; waitQ();
  endtask

  task automatic getBit(output bit b);
    mDrive = 1'b0; waitQ(); scl = 1'b1; waitQ(); b = (sda !== 1'b0); waitQ(); scl = 1'b0; waitQ();
  endtask

  task automatic writeByte(logic [7:0] d, output bit ack);
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    getBit(ack);
  endtask

  task automatic readByte(bit masterAck, output logic [7:0] d);
    bit b;
    for (int i = 7; i >= 0; i--) begin getBit(b); d[i] = b; end
    sendBit(!masterAck);
  endtask

  task automatic addrPhase(bit rd, string name);
    bit ack;
    writeByte({SADDR, rd}, ack);
    check({name, " addr ack"}, 32'(ack), 32'd0);
  endtask

  task automatic setOffset(logic [7:0] off);
    bit ack;
    addrPhase(1'b0, "offset");
    writeByte(off, ack);
    check("offset ack", 32'(ack), 32'd0);
    ptr = int'(off) % DEPTH;
  endtask

  task automatic txWrite(logic [7:0] off, byteQ_t data);
    bit ack;
    busStart();
    setOffset(off);
    foreach (data[i]) begin
      wrQ.push_back({8'(ptr), data[i]});
      mem[ptr] = data[i];
      ptr = (ptr + 1) % DEPTH;
      writeByte(data[i], ack);
      check("wr data ack", 32'(ack), 32'd0);
    end
    busStop();
  endtask

  task automatic txRead(bit withOff, logic [7:0] off, int n);
    logic [7:0] got, exp;
    busStart();
    if (withOff) begin setOffset(off); busStart(); end
    addrPhase(1'b1, "rd");
    expRdEn += n;
    for (int i = 0; i < n; i++) begin
      exp = mem[ptr];
      readByte(i < n - 1, got);
      check("rd data", 32'(got), 32'(exp));
      if (i < n - 1) ptr = (ptr + 1) % DEPTH;
    end
    busStop();
    check("oReadEn count", 32'(rdEnCnt), 32'(expRdEn));
  endtask

  // Hold SCL high in bit 4 of the current byte, then pull reset.
  task automatic resetInBit4(string name);
    bit b;
    for (int i = 0; i < 3; i++) getBit(b);
    mDrive = 1'b0; waitQ(); scl = 1'b1; waitQ();
    iRstn = 1'b0;
    #1;
    check({name, " sda released"}, 32'(sda !== 1'b0), 32'd1);
    check({name, " busy"}, 32'(busIf.oBusy), 32'd0);
    check({name, " state"}, 32'(busIf.ovState), 32'(IDLE));
    modelReset();
    waitQ(); iRstn = 1'b1; waitQ();
  endtask

  initial begin
    byteQ_t d;
    bit ack;
    modelReset();
    repeat (3) @(negedge iClk);
    check("reset state", 32'(busIf.ovState), 32'(IDLE));
    check("reset outputs", {14'h0, busIf.oWriteEn, busIf.oReadEn, busIf.ovWrOffset, busIf.ovWrData}, 32'd0);
    check("reset busy/sda", {30'h0, busIf.oBusy, sda !== 1'b0}, 32'd1);
    iRstn = 1'b1;
    waitQ();

    d = {8'hA5, 8'h5A};
    txWrite(8'h03, d);
    txRead(1'b1, 8'h03, 2);

    busStart();
    quiet = 1'b1;
    writeByte({7'h09, 1'b0}, ack);
    check("mismatch addr nack", 32'(ack), 32'd1);
    writeByte(8'hFF, ack);
    check("mismatch data nack", 32'(ack), 32'd1);
    check("mismatch state", 32'(busIf.ovState), 32'(IGNORE));
    quiet = 1'b0;
    busStop();
    check("mismatch idle after stop", 32'(busIf.ovState), 32'(IDLE));
    check("mismatch never drove sda", 32'(quietHits), 32'd0);

    d = {8'h01, 8'h02};
    txWrite(8'h0F, d);
    txRead(1'b1, 8'h0F, 2);
    d = {8'h77};
    txWrite(8'h1F, d);
    txRead(1'b1, 8'h0F, 2);
    txRead(1'b0, 8'h00, 1);

    // Stop after 5 data bits: no write, pointer unchanged, busy drops SYNC_STAGES+1 clocks later.
    busStart();
    setOffset(8'h07);
    for (int i = 0; i < 5; i++) sendBit(1'(i));
    mDrive = 1'b1; waitQ(); scl = 1'b1; waitQ(); mDrive = 1'b0;
    @(posedge iClk); @(posedge iClk); #1;
    check("busy before stop seen", 32'(busIf.oBusy), 32'd1);
    @(posedge iClk); #1;
    check("busy after stop", 32'(busIf.oBusy), 32'd0);
    check("idle after stop", 32'(busIf.ovState), 32'(IDLE));
    waitQ();
    txRead(1'b0, 8'h00, 1);

    d = {8'h00};
    txWrite(8'h09, d);
    busStart();
    setOffset(8'h09);
    busStart();
    addrPhase(1'b1, "rst rd");
    expRdEn += 1;
    resetInBit4("rd reset");

    busStart();
    setOffset(8'h03);
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    resetInBit4("wr reset");
    txRead(1'b1, 8'h03, 2);

    for (int t = 0; t < 14; t++) begin
      int n;
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        d.delete();
        repeat (n) d.push_back(8'($urandom));
        txWrite(8'($urandom), d);
      end else begin
        txRead(1'($urandom_range(0, 1)), 8'($urandom), n);
      end
    end

    repeat (10) @(negedge iClk);
    check("writes drained", 32'(wrQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
